// File: rtl/instruction_loader_if.sv
// Byte-stream handshake between an upstream byte source and the instruction loader.
// A byte moves on a rising edge when byte_valid and byte_ready are both high.
interface instruction_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/instruction_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until every word has been written.
module instruction_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  instruction_loader_if.slave   byte_if,
  output logic                  imem_write_enable,
  output logic [ADDR_W-1:0]     imem_address,
  output logic [31:0]           imem_write_data,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR
  } state_e;

  localparam int CNT_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q;
  logic [15:0]        len_q;
  logic [1:0]         byte_cnt_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [23:0]        asm_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic        in_stream;
  logic        accept;
  logic        restart;
  logic [15:0] len_full;
  logic        too_long;
  logic        last_byte;
  logic        last_word;

  assign accept    = byte_if.byte_valid && in_stream;
  assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_full  = {byte_if.byte_data, len_lo_q};
  assign too_long  = {16'b0, len_full} > 32'(DEPTH);
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0) state_d = S_DONE;
          else if (too_long)     state_d = S_ERROR;
          else                   state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && last_byte && last_word) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_stream = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        in_stream = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  done  = 1'b1;
      S_ERROR: error = 1'b1;
      default: ;
    endcase
    byte_if.byte_ready = in_stream;
    // The final word strobes in the first DONE cycle; the core is released one cycle later.
    core_hold = (state_q != S_DONE) || we_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
      end
      if (accept) begin
        unique case (state_q)
          S_LEN_LO: len_lo_q <= byte_if.byte_data;
          S_LEN_HI: len_q    <= len_full;
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= byte_if.byte_data;
              2'd1: asm_q[15:8]  <= byte_if.byte_data;
              2'd2: asm_q[23:16] <= byte_if.byte_data;
              default: begin
                we_q       <= 1'b1;
                addr_q     <= word_cnt_q[ADDR_W-1:0];
                wdata_q    <= {byte_if.byte_data, asm_q};
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_write_enable = we_q;
  assign imem_address      = addr_q;
  assign imem_write_data   = wdata_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized and directed stimulus for instruction_loader, checked against a
// stream-level model that turns each byte list into an expected list of writes.
module tb_instruction_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              core_hold, busy, done, error;

  always #5 clock = ~clock;

  instruction_loader_if bus ();

  instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .byte_if           (bus),
    .imem_write_enable (we),
    .imem_address      (addr),
    .imem_write_data   (wdata),
    .core_hold         (core_hold),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit tog   = 1'b0;

  logic [7:0]  stim_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every strobe must match the next word the model expects.
  always @(negedge clock) begin
    tog <= ~tog;
    if (reset && we) begin
      if (exp_data_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else begin
        check("strobe_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
        check("strobe_data", wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic make_stim(input int n, input bit payload);
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    if (payload)
      for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
  endtask

  // outcome: 0 = completes in DONE, 1 = rejected into ERROR.
  task automatic model(output int outcome, output int n);
    n = int'({stim_q[1], stim_q[0]});
    outcome = (n > DEPTH) ? 1 : 0;
    if (outcome == 0)
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(w);
        exp_data_q.push_back({stim_q[2+4*w+3], stim_q[2+4*w+2], stim_q[2+4*w+1], stim_q[2+4*w]});
      end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 valid toggling every cycle, 2 random valid.
  task automatic feed(input int gap_mode, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int budget;
      bit taken;
      budget = 0;
      taken  = 1'b0;
      while (!taken) begin
        @(negedge clock);
        case (gap_mode)
          0:       bus.byte_valid = 1'b1;
          1:       bus.byte_valid = tog;
          default: bus.byte_valid = 1'($urandom_range(0, 1));
        endcase
        bus.byte_data = bus.byte_valid ? stim_q[i] : 8'($urandom);
        taken = bus.byte_valid && bus.byte_ready;
        @(posedge clock);
        budget++;
        if (!taken && budget > 50) begin
          check("byte_timeout", 32'd0, 32'd1);
          #1 bus.byte_valid = 1'b0;
          return;
        end
      end
    end
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic finish_load(input int outcome, input int n);
    @(negedge clock);
    if (outcome == 1) begin
      check("err_error", 32'(error), 32'd1);
      check("err_done",  32'(done), 32'd0);
      check("err_ready", 32'(bus.byte_ready), 32'd0);
      check("err_busy",  32'(busy), 32'd0);
      check("err_hold",  32'(core_hold), 32'd1);
    end else begin
      if (n > 0) begin
        check("final_we",       32'(we), 32'd1);
        check("hold_on_strobe", 32'(core_hold), 32'd1);
        @(negedge clock);
        check("we_after", 32'(we), 32'd0);
      end
      check("done_done",  32'(done), 32'd1);
      check("done_error", 32'(error), 32'd0);
      check("done_hold",  32'(core_hold), 32'd0);
      check("done_ready", 32'(bus.byte_ready), 32'd0);
    end
    check("words_left", 32'(exp_data_q.size()), 32'd0);
  endtask

  task automatic run_load(input int gap_mode);
    int outcome, n;
    model(outcome, n);
    pulse_start();
    feed(gap_mode, 0, stim_q.size() - 1);
    finish_load(outcome, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"},  32'(core_hold), 32'd1);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_we"},    32'(we), 32'd0);
    check({tag, "_addr"},  32'(addr), 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int outcome, n;
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);

    // Two-word program with known contents.
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(0);

    // Zero-length load.
    make_stim(0, 1'b0);
    run_load(0);

    // Oversized length is rejected, then a second start reopens the stream.
    make_stim(DEPTH + 1, 1'b0);
    run_load(0);
    pulse_start();
    check("restart_busy",  32'(busy), 32'd1);
    check("restart_ready", 32'(bus.byte_ready), 32'd1);
    check("restart_error", 32'(error), 32'd0);
    make_stim(0, 1'b0);
    model(outcome, n);
    feed(0, 0, 1);
    finish_load(outcome, n);

    // Same program with valid toggling every cycle.
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(1);

    // Reset after 6 of 8 payload bytes: only word 0 may be written.
    make_stim(2, 1'b1);
    model(outcome, n);
    void'(exp_addr_q.pop_back());
    void'(exp_data_q.pop_back());
    pulse_start();
    feed(0, 0, 7);
    @(negedge clock);
    reset = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_hold", 32'(core_hold), 32'd1);
    check("abort_words_left", 32'(exp_data_q.size()), 32'd0);
    make_stim(1, 1'b1);
    run_load(0);

    // start held high through part of DATA is ignored.
    make_stim(1, 1'b1);
    model(outcome, n);
    pulse_start();
    start = 1'b1;
    feed(0, 0, 3);
    @(negedge clock);
    check("start_in_data_busy",  32'(busy), 32'd1);
    check("start_in_data_ready", 32'(bus.byte_ready), 32'd1);
    start = 1'b0;
    feed(0, 4, 5);
    finish_load(outcome, n);
    pulse_start();
    check("relaunch_hold", 32'(core_hold), 32'd1);
    check("relaunch_done", 32'(done), 32'd0);
    check("relaunch_busy", 32'(busy), 32'd1);
    make_stim(0, 1'b0);
    model(outcome, n);
    feed(0, 0, 1);
    finish_load(outcome, n);

    // Boundaries: a full-depth image and the largest length.
    make_stim(DEPTH, 1'b1);
    run_load(0);
    make_stim(16'hFFFF, 1'b0);
    run_load(2);

    // Random loads with random valid gaps.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 9) == 0) make_stim(int'($urandom_range(DEPTH + 1, 65535)), 1'b0);
      else                           make_stim(int'($urandom_range(0, 9)), 1'b1);
      run_load(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
